// File: rtl/lms_debug_port.sv
// lms_debug_port: host-side end of the LMS equalizer debug link.
// Decodes READ (0x01) and WRITE (0x02) byte commands from the UART byte layer.
// READ streams a snapshot of the coefficient bus and error signal back to the host.
// WRITE collects Nw coefficient bytes, loads them into the LMS and returns 0xA5.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   S_IDLE     | waiting for a command byte; other bytes are ignored
//   S_TX_COEF  | sending snapshot coefficient r_idx, sign-extended to 8 bits
//   S_TX_ERR_H | sending error snapshot bits [15:8] (sign-extended to 16)
//   S_TX_ERR_L | sending error snapshot bits [7:0]
//   S_RX_COEF  | collecting coefficient bytes into staging, idle timer running
//   S_LOAD     | staging captured; load strobe is being registered
//   S_TX_ACK   | debug_load cycle, then 0xA5 offered until accepted
module lms_debug_port #(
  parameter int Nw      = 9,
  parameter int NBw     = 7,
  parameter int NBe     = 9,
  parameter int TIMEOUT = 1000000
) (
  input  logic                clkA,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [Nw*NBw-1:0]   coeff,
  input  logic [NBe-1:0]      e_in,
  output logic [Nw*NBw-1:0]   o_coeffs,
  output logic                debug_load,
  output logic                busy
);

  localparam int IDXW = $clog2(Nw + 1);
  localparam int TMRW = $clog2(TIMEOUT);

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_COEF,
    S_TX_ERR_H,
    S_TX_ERR_L,
    S_RX_COEF,
    S_LOAD,
    S_TX_ACK
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [IDXW-1:0]       r_idx;
  logic [TMRW-1:0]       r_timer;
  logic [Nw*NBw-1:0]     r_snap_coeff;
  logic [NBe-1:0]        r_snap_err;
  logic [Nw*NBw-1:0]     r_stage;
  logic [Nw*NBw-1:0]     r_coeffs;
  logic                  r_debug_load;

  logic                  w_last_idx;
  logic                  w_tmo;
  logic signed [NBw-1:0] w_coef_sel;
  logic signed [NBe-1:0] w_err_sel;
  logic [7:0]            w_coef_ext;
  logic [15:0]           w_err_ext;

  assign w_last_idx = (r_idx == IDXW'(Nw - 1));
  assign w_tmo      = (r_timer == TMRW'(TIMEOUT - 1));

  // Signed casts give sign extension for any legal NBw/NBe, including full width.
  assign w_coef_sel = r_snap_coeff[r_idx*NBw +: NBw];
  assign w_err_sel  = r_snap_err;
  assign w_coef_ext = 8'(w_coef_sel);
  assign w_err_ext  = 16'(w_err_sel);

  assign o_coeffs   = r_coeffs;
  assign debug_load = r_debug_load;
  assign busy       = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clkA or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and transmit outputs. tx_valid is a pure function of state, so
  // acceptance is decoded from tx_ready directly to avoid a combinational loop.
  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && rx_data == CMD_READ)       w_next = S_TX_COEF;
        else if (rx_valid && rx_data == CMD_WRITE) w_next = S_RX_COEF;
      end
      S_TX_COEF: begin
        tx_valid = 1'b1;
        tx_data  = w_coef_ext;
        if (tx_ready && w_last_idx) w_next = S_TX_ERR_H;
      end
      S_TX_ERR_H: begin
        tx_valid = 1'b1;
        tx_data  = w_err_ext[15:8];
        if (tx_ready) w_next = S_TX_ERR_L;
      end
      S_TX_ERR_L: begin
        tx_valid = 1'b1;
        tx_data  = w_err_ext[7:0];
        if (tx_ready) w_next = S_IDLE;
      end
      S_RX_COEF: begin
        if (rx_valid) begin
          if (w_last_idx) w_next = S_LOAD;
        end else if (w_tmo) begin
          w_next = S_IDLE;
        end
      end
      S_LOAD: begin
        w_next = S_TX_ACK;
      end
      S_TX_ACK: begin
        // The first TX_ACK cycle carries the load strobe; the ack follows it.
        if (!r_debug_load) begin
          tx_valid = 1'b1;
          tx_data  = ACK_BYTE;
          if (tx_ready) w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: byte index, idle timer, READ snapshot, WRITE staging and load.
  always_ff @(posedge clkA or negedge reset) begin
    if (!reset) begin
      r_idx        <= '0;
      r_timer      <= '0;
      r_snap_coeff <= '0;
      r_snap_err   <= '0;
      r_stage      <= '0;
      r_coeffs     <= '0;
      r_debug_load <= 1'b0;
    end else begin
      r_debug_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rx_valid && rx_data == CMD_READ) begin
            r_snap_coeff <= coeff;
            r_snap_err   <= e_in;
            r_idx        <= '0;
          end else if (rx_valid && rx_data == CMD_WRITE) begin
            r_idx   <= '0;
            r_timer <= '0;
          end
        end
        S_TX_COEF: begin
          if (tx_ready) r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
        end
        S_RX_COEF: begin
          if (rx_valid) begin
            r_stage[r_idx*NBw +: NBw] <= rx_data[NBw-1:0];
            r_idx                     <= r_idx + 1'b1;
            r_timer                   <= '0;
          end else if (!w_tmo) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_LOAD: begin
          r_coeffs     <= r_stage;
          r_debug_load <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lms_debug_port.sv
// Self-checking bench for lms_debug_port: table-driven READ vectors, directed
// WRITE / timeout / reset / ignored-byte sequences, then randomized traffic
// checked against a byte-level reference model.
module tb_lms_debug_port;

  localparam int NW  = 9;
  localparam int NBW = 7;
  localparam int NBE = 9;
  localparam int TMO = 16;
  localparam int NB  = NW + 2;

  logic                clkA = 1'b0;
  logic                reset;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [NW*NBW-1:0]   coeff;
  logic [NBE-1:0]      e_in;
  logic [NW*NBW-1:0]   o_coeffs;
  logic                debug_load;
  logic                busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_loads  = 0;
  logic [NW*NBW-1:0] model_o = '0;

  lms_debug_port #(.Nw(NW), .NBw(NBW), .NBe(NBE), .TIMEOUT(TMO)) dut (
    .clkA(clkA), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .coeff(coeff), .e_in(e_in), .o_coeffs(o_coeffs),
    .debug_load(debug_load), .busy(busy)
  );

  always #5 clkA = ~clkA;

  always @(negedge clkA) if (debug_load) n_loads++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [NW*NBW-1:0] c;
    logic [NBE-1:0]    e;
    int                mode;
    bit                inject;
    logic [8*NB-1:0]   exp;
    string             nm;
  } rd_vec_t;

  rd_vec_t tbl[4];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Expected READ byte stream, byte 0 in the most significant position.
  function automatic logic [8*NB-1:0] model_read(input logic [NW*NBW-1:0] c,
                                                 input logic [NBE-1:0] e);
    logic [8*NB-1:0] r;
    int v;
    int u;
    r = '0;
    for (int h = 0; h < NW; h++) begin
      v = int'((c >> (NBW * h)) & ((1 << NBW) - 1));
      if (v >= (1 << (NBW - 1))) v -= (1 << NBW);
      r[8*(NB-1-h) +: 8] = 8'(v & 255);
    end
    v = int'(e);
    if (v >= (1 << (NBE - 1))) v -= (1 << NBE);
    u = v & 'hFFFF;
    r[15:8] = 8'(u / 256);
    r[7:0]  = 8'(u % 256);
    return r;
  endfunction

  // Expected loaded vector: low NBw bits of byte k land in coefficient k.
  function automatic logic [NW*NBW-1:0] model_write(input logic [8*NW-1:0] b);
    logic [NW*NBW-1:0] r;
    r = '0;
    for (int k = 0; k < NW; k++) r[NBW*k +: NBW] = b[8*k +: NBW];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clkA); #1;
    rx_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready toggles 1/0, 2: random ready.
  task automatic do_read(input logic [NW*NBW-1:0] c, input logic [NBE-1:0] e,
                         input int mode, input bit inject,
                         input logic [8*NB-1:0] exp, input string nm);
    int n;
    int cyc;
    bit have_hold;
    logic [7:0] hold;
    coeff = c;
    e_in  = e;
    send_byte(8'h01);
    n = 0; cyc = 0; have_hold = 0; hold = 8'h00;
    while (n < NB && cyc < 200) begin
      coeff    = (NW*NBW)'({$urandom, $urandom});
      e_in     = NBE'($urandom);
      rx_valid = inject && (cyc == 1 || cyc == 2);
      rx_data  = (cyc == 1) ? 8'h02 : 8'h11;
      if (mode == 0)      tx_ready = 1'b1;
      else if (mode == 1) tx_ready = (cyc % 2 == 0);
      else                tx_ready = 1'($urandom_range(0, 1));
      @(negedge clkA);
      check({nm, " tx_valid"}, 64'(tx_valid), 64'(1));
      if (have_hold) check({nm, " stall hold"}, 64'(tx_data), 64'(hold));
      if (tx_ready) begin
        check($sformatf("%s byte%0d", nm, n), 64'(tx_data), 64'(exp[8*(NB-1-n) +: 8]));
        n++;
        have_hold = 0;
      end else begin
        hold = tx_data;
        have_hold = 1;
      end
      @(posedge clkA); #1;
      cyc++;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    check({nm, " byte count"}, 64'(n), 64'(NB));
    if (mode == 0) check({nm, " no gaps"}, 64'(cyc), 64'(NB));
    @(negedge clkA);
    check({nm, " tx_valid end"}, 64'(tx_valid), 64'(0));
    check({nm, " busy end"}, 64'(busy), 64'(0));
    @(posedge clkA); #1;
  endtask

  task automatic do_write(input logic [8*NW-1:0] b, input int gmax, input string nm);
    logic [NW*NBW-1:0] exp;
    int l0;
    int stalls;
    exp = model_write(b);
    l0  = n_loads;
    send_byte(8'h02);
    for (int k = 0; k < NW; k++) begin
      repeat ($urandom_range(0, gmax)) begin
        @(negedge clkA);
        check({nm, " busy rx"}, 64'(busy), 64'(1));
        @(posedge clkA); #1;
      end
      send_byte(b[8*k +: 8]);
    end
    @(negedge clkA);
    check({nm, " no early load"}, 64'(debug_load), 64'(0));
    check({nm, " o_coeffs before load"}, 64'(o_coeffs), 64'(model_o));
    check({nm, " no early tx"}, 64'(tx_valid), 64'(0));
    @(posedge clkA); #1;
    @(negedge clkA);
    check({nm, " debug_load"}, 64'(debug_load), 64'(1));
    check({nm, " o_coeffs"}, 64'(o_coeffs), 64'(exp));
    check({nm, " tx during load"}, 64'(tx_valid), 64'(0));
    model_o = exp;
    @(posedge clkA); #1;
    rx_valid = 1'b1;
    rx_data  = 8'h01;
    @(negedge clkA);
    check({nm, " load one cycle"}, 64'(debug_load), 64'(0));
    check({nm, " ack valid"}, 64'(tx_valid), 64'(1));
    check({nm, " ack byte"}, 64'(tx_data), 64'(8'hA5));
    stalls = $urandom_range(0, 2);
    repeat (stalls) begin
      @(posedge clkA); #1;
      rx_valid = 1'b0;
      @(negedge clkA);
      check({nm, " ack held"}, 64'({tx_valid, tx_data}), 64'({1'b1, 8'hA5}));
    end
    tx_ready = 1'b1;
    @(posedge clkA); #1;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    @(negedge clkA);
    check({nm, " busy after ack"}, 64'(busy), 64'(0));
    check({nm, " tx after ack"}, 64'(tx_valid), 64'(0));
    check({nm, " load count"}, 64'(n_loads - l0), 64'(1));
    @(posedge clkA); #1;
  endtask

  initial begin
    logic [8*NW-1:0]   wb;
    logic [NW*NBW-1:0] rc;
    logic [NBE-1:0]    re;
    int l0;

    reset = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b0;
    coeff = '0; e_in = '0;

    tbl[0] = '{c: (NW*NBW)'(7'h20) << 28, e: 9'h1F0, mode: 0, inject: 0,
               exp: 88'h00_00_00_00_20_00_00_00_00_FF_F0, nm: "rd_basic"};
    tbl[1] = '{c: (NW*NBW)'(7'h20) << 28, e: 9'h1F0, mode: 1, inject: 0,
               exp: 88'h00_00_00_00_20_00_00_00_00_FF_F0, nm: "rd_stall"};
    tbl[2] = '{c: {NW{7'h7F}}, e: 9'h0FF, mode: 1, inject: 0,
               exp: 88'hFF_FF_FF_FF_FF_FF_FF_FF_FF_00_FF, nm: "rd_neg1"};
    tbl[3] = '{c: ((NW*NBW)'(7'h40) << 56) | (NW*NBW)'(7'h3F), e: 9'h100, mode: 1, inject: 1,
               exp: 88'h3F_00_00_00_00_00_00_00_C0_FF_00, nm: "rd_inject"};

    #13;
    check("rst tx_valid", 64'(tx_valid), 64'(0));
    check("rst tx_data", 64'(tx_data), 64'(0));
    check("rst o_coeffs", 64'(o_coeffs), 64'(0));
    check("rst debug_load", 64'(debug_load), 64'(0));
    check("rst busy", 64'(busy), 64'(0));
    @(posedge clkA); #1;
    reset = 1'b1;
    @(posedge clkA); #1;

    for (int i = 0; i < 4; i++)
      do_read(tbl[i].c, tbl[i].e, tbl[i].mode, tbl[i].inject, tbl[i].exp, tbl[i].nm);

    for (int k = 0; k < NW; k++) wb[8*k +: 8] = 8'(k + 1);
    do_write(wb, 0, "wr_seq");

    // Partial WRITE followed by silence must abort without loading.
    l0 = n_loads;
    send_byte(8'h02);
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    for (int i = 1; i <= TMO; i++) begin
      @(posedge clkA); #1;
      @(negedge clkA);
      check($sformatf("tmo busy c%0d", i), 64'(busy), 64'(i < TMO));
      check("tmo tx_valid", 64'(tx_valid), 64'(0));
    end
    check("tmo no load", 64'(n_loads - l0), 64'(0));
    check("tmo o_coeffs kept", 64'(o_coeffs), 64'(model_o));
    @(posedge clkA); #1;

    // Reset in the middle of a READ, with byte 5 on the wire.
    rc = (NW*NBW)'({$urandom, $urandom});
    re = NBE'($urandom);
    coeff = rc; e_in = re;
    send_byte(8'h01);
    tx_ready = 1'b1;
    repeat (5) @(posedge clkA);
    #1;
    check("pre-rst byte5", 64'({tx_valid, tx_data}), 64'({1'b1, model_read(rc, re)[8*(NB-1-5) +: 8]}));
    reset = 1'b0;
    #2;
    check("mid-rst tx_valid", 64'(tx_valid), 64'(0));
    check("mid-rst busy", 64'(busy), 64'(0));
    check("mid-rst o_coeffs", 64'(o_coeffs), 64'(0));
    model_o = '0;
    tx_ready = 1'b0;
    @(posedge clkA); #1;
    reset = 1'b1;
    @(posedge clkA); #1;
    do_read(tbl[0].c, tbl[0].e, 0, 0, tbl[0].exp, "rd_after_rst");

    // Unknown command in IDLE.
    send_byte(8'h7E);
    repeat (3) begin
      @(negedge clkA);
      check("unk busy", 64'(busy), 64'(0));
      check("unk tx_valid", 64'(tx_valid), 64'(0));
      @(posedge clkA); #1;
    end

    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        rc = (NW*NBW)'({$urandom, $urandom});
        re = NBE'($urandom);
        do_read(rc, re, 2, 1'($urandom_range(0, 1)), model_read(rc, re),
                $sformatf("rnd_rd%0d", it));
      end else begin
        for (int k = 0; k < NW; k++) wb[8*k +: 8] = 8'($urandom);
        do_write(wb, 5, $sformatf("rnd_wr%0d", it));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
